morse_rx: RTL and testbench

//  Morse receiver: samples a serial on/off keyed line once per clk_morse tick (1 tick = 1 unit).

---
 rtl/morse_rx.sv | 187 ++++++++++++++++++
 tb/tb_morse_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/morse_rx.sv
// morse_rx: samples a keyed line once per unit tick, classifies mark/space
// run lengths into elements and gaps, and decodes each character to ASCII
// on a valid/ready port with a sticky overrun flag.
module morse_rx #(
  parameter int DOT_MAX  = 2,
  parameter int CHAR_GAP = 3,
  parameter int WORD_GAP = 7,
  parameter int CNT_W    = 4
) (
  input  logic       clk_morse,
  input  logic       arst_n,
  input  logic       morse_in,
  output logic [7:0] ascii_out,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       decode_err,
  output logic       overrun,
  input  logic       overrun_clr
);

  typedef enum logic [1:0] {IDLE, MARK, GAP, WGAP} state_t;

  localparam logic [CNT_W-1:0] RUN_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DOT_LIM  = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] CGAP_LIM = CNT_W'(CHAR_GAP);
  localparam logic [CNT_W-1:0] WGAP_LIM = CNT_W'(WORD_GAP);

  state_t           r_state;
  logic [CNT_W-1:0] r_run;
  logic [2:0]       r_len;
  logic [5:0]       r_pat;
  logic             r_bad;
  logic             r_word_pend;
  logic [7:0]       r_out;
  logic             r_valid;
  logic             r_err;
  logic             r_ovr;

  // Reverse LUT: {known, ascii}. Patterns are first-element-in-MSB, dash=1.
  function automatic logic [8:0] lut(input logic [2:0] len, input logic [5:0] pat);
    logic [8:0] r;
    r = {1'b0, 8'h3F};
    case ({len, pat})
      {3'd2, 6'd1}:  r = {1'b1, 8'h41}; // A
      {3'd4, 6'd8}:  r = {1'b1, 8'h42}; // B
      {3'd4, 6'd10}: r = {1'b1, 8'h43}; // C
      {3'd3, 6'd4}:  r = {1'b1, 8'h44}; // D
      {3'd1, 6'd0}:  r = {1'b1, 8'h45}; // E
      {3'd4, 6'd2}:  r = {1'b1, 8'h46}; // F
      {3'd3, 6'd6}:  r = {1'b1, 8'h47}; // G
      {3'd4, 6'd0}:  r = {1'b1, 8'h48}; // H
      {3'd2, 6'd0}:  r = {1'b1, 8'h49}; // I
      {3'd4, 6'd7}:  r = {1'b1, 8'h4A}; // J
      {3'd3, 6'd5}:  r = {1'b1, 8'h4B}; // K
      {3'd4, 6'd4}:  r = {1'b1, 8'h4C}; // L
      {3'd2, 6'd3}:  r = {1'b1, 8'h4D}; // M
      {3'd2, 6'd2}:  r = {1'b1, 8'h4E}; // N
      {3'd3, 6'd7}:  r = {1'b1, 8'h4F}; // O
      {3'd4, 6'd6}:  r = {1'b1, 8'h50}; // P
      {3'd4, 6'd13}: r = {1'b1, 8'h51}; // Q
      {3'd3, 6'd2}:  r = {1'b1, 8'h52}; // R
      {3'd3, 6'd0}:  r = {1'b1, 8'h53}; // S
      {3'd1, 6'd1}:  r = {1'b1, 8'h54}; // T
      {3'd3, 6'd1}:  r = {1'b1, 8'h55}; // U
      {3'd4, 6'd1}:  r = {1'b1, 8'h56}; // V
      {3'd3, 6'd3}:  r = {1'b1, 8'h57}; // W
      {3'd4, 6'd9}:  r = {1'b1, 8'h58}; // X
      {3'd4, 6'd11}: r = {1'b1, 8'h59}; // Y
      {3'd4, 6'd12}: r = {1'b1, 8'h5A}; // Z
      {3'd5, 6'd31}: r = {1'b1, 8'h30}; // 0
      {3'd5, 6'd15}: r = {1'b1, 8'h31}; // 1
      {3'd5, 6'd7}:  r = {1'b1, 8'h32}; // 2
      {3'd5, 6'd3}:  r = {1'b1, 8'h33}; // 3
      {3'd5, 6'd1}:  r = {1'b1, 8'h34}; // 4
      {3'd5, 6'd0}:  r = {1'b1, 8'h35}; // 5
      {3'd5, 6'd16}: r = {1'b1, 8'h36}; // 6
      {3'd5, 6'd24}: r = {1'b1, 8'h37}; // 7
      {3'd5, 6'd28}: r = {1'b1, 8'h38}; // 8
      {3'd5, 6'd30}: r = {1'b1, 8'h39}; // 9
      default:       r = {1'b0, 8'h3F};
    endcase
    return r;
  endfunction

  logic [CNT_W-1:0] w_run_inc;
  logic             w_is_dash;
  logic [8:0]       w_lut;
  logic             w_char_err;
  logic             w_emit_char;
  logic             w_emit_sp;
  logic [7:0]       w_emit_data;
  logic             w_accept;

  assign w_run_inc   = (r_run == RUN_MAX) ? r_run : r_run + 1'b1;
  assign w_is_dash   = (r_run > DOT_LIM);
  assign w_lut       = lut(r_len, r_pat);
  assign w_char_err  = r_bad | ~w_lut[8];
  assign w_emit_char = (r_state == GAP)  && !morse_in && (w_run_inc >= CGAP_LIM);
  assign w_emit_sp   = (r_state == WGAP) && !morse_in && (w_run_inc >= WGAP_LIM) && r_word_pend;
  assign w_emit_data = w_emit_sp ? 8'h20 : (w_char_err ? 8'h3F : w_lut[7:0]);
  assign w_accept    = r_valid && ascii_ready;

  // Run-length FSM: builds the element code and decides when a char/space closes.
  always_ff @(posedge clk_morse or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= IDLE;
      r_run       <= '0;
      r_len       <= '0;
      r_pat       <= '0;
      r_bad       <= 1'b0;
      r_word_pend <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (morse_in) begin
          r_state <= MARK;
          r_run   <= CNT_W'(1);
        end
        MARK: if (morse_in) begin
          r_run <= w_run_inc;
        end else begin
          // A seventh element cannot be stored; flag the char as bad instead.
          if (r_len == 3'd6) r_bad <= 1'b1;
          else begin
            r_pat <= {r_pat[4:0], w_is_dash};
            r_len <= r_len + 3'd1;
          end
          r_state <= GAP;
          r_run   <= CNT_W'(1);
        end
        GAP: if (morse_in) begin
          r_state <= MARK;
          r_run   <= CNT_W'(1);
        end else if (w_emit_char) begin
          r_len       <= '0;
          r_pat       <= '0;
          r_bad       <= 1'b0;
          r_word_pend <= 1'b1;
          r_state     <= WGAP;
          r_run       <= w_run_inc;
        end else begin
          r_run <= w_run_inc;
        end
        WGAP: if (morse_in) begin
          r_state     <= MARK;
          r_run       <= CNT_W'(1);
          r_word_pend <= 1'b0;
        end else if (w_run_inc >= WGAP_LIM) begin
          r_word_pend <= 1'b0;
          r_state     <= IDLE;
          r_run       <= w_run_inc;
        end else begin
          r_run <= w_run_inc;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output register: load on emit when the slot is free or draining this edge.
  always_ff @(posedge clk_morse or negedge arst_n) begin
    if (!arst_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_err <= w_emit_char && w_char_err;
      if (w_emit_char || w_emit_sp) begin
        if (!r_valid || w_accept) begin
          r_out   <= w_emit_data;
          r_valid <= 1'b1;
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      // Set wins over clear on the same edge.
      if ((w_emit_char || w_emit_sp) && r_valid && !ascii_ready) r_ovr <= 1'b1;
      else if (overrun_clr)                                        r_ovr <= 1'b0;
    end
  end

  assign ascii_out   = r_out;
  assign ascii_valid = r_valid;
  assign decode_err  = r_err;
  assign overrun     = r_ovr;

endmodule

// File: tb/tb_morse_rx.sv
// tb_morse_rx: scoreboard bench for morse_rx; directed cases plus random text.
module tb_morse_rx;

  logic       clk_morse = 1'b0;
  logic       arst_n;
  logic       morse_in;
  logic [7:0] ascii_out;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       decode_err;
  logic       overrun;
  logic       overrun_clr;

  int n_chk  = 0;
  int n_fail = 0;
  bit rnd_mode = 1'b0;
  int rdy_zeros = 0;
  logic [8:0] exp_q[$];

  morse_rx dut (
    .clk_morse  (clk_morse),
    .arst_n     (arst_n),
    .morse_in   (morse_in),
    .ascii_out  (ascii_out),
    .ascii_valid(ascii_valid),
    .ascii_ready(ascii_ready),
    .decode_err (decode_err),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk_morse = ~clk_morse;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_out(input logic [7:0] c, input logic err);
    exp_q.push_back({err, c});
  endtask

  // One unit tick; in random mode ready is low at most two ticks in a row,
  // which is shorter than the minimum spacing between two emits.
  task automatic tick(input logic v);
    morse_in = v;
    if (rnd_mode) begin
      if (rdy_zeros < 2 && $urandom_range(3, 0) == 0) begin
        ascii_ready = 1'b0;
        rdy_zeros++;
      end else begin
        ascii_ready = 1'b1;
        rdy_zeros = 0;
      end
    end
    @(posedge clk_morse);
    #1;
  endtask

  // Key a dot/dash string; dot=1..2 ticks, dash=3..20, element gap 1..2.
  task automatic send(input string code, input int gap, input bit rnd);
    int n;
    for (int i = 0; i < code.len(); i++) begin
      if (code[i] == 8'h2D) n = rnd ? int'($urandom_range(20, 3)) : 3;
      else                  n = rnd ? int'($urandom_range(2, 1)) : 1;
      repeat (n) tick(1'b1);
      if (i != code.len() - 1) repeat (rnd ? int'($urandom_range(2, 1)) : 1) tick(1'b0);
    end
    repeat (gap) tick(1'b0);
  endtask

  // Monitor: pops on each newly presented character, checks hold and stray errors.
  initial begin
    logic p_valid, p_hs;
    logic [7:0] p_out;
    logic [8:0] e;
    p_valid = 1'b0; p_hs = 1'b0; p_out = '0;
    forever begin
      @(negedge clk_morse);
      if (arst_n !== 1'b1) begin
        p_valid = 1'b0; p_hs = 1'b0;
      end else begin
        if (ascii_valid && (!p_valid || p_hs)) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", {24'h0, ascii_out}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("data", {24'h0, ascii_out}, {24'h0, e[7:0]});
            chk("decode_err", {31'h0, decode_err}, {31'h0, e[8]});
          end
        end else begin
          if (ascii_valid) chk("hold", {24'h0, ascii_out}, {24'h0, p_out});
          chk("stray_err", {31'h0, decode_err}, 32'h0);
        end
        p_valid = ascii_valid;
        p_hs    = ascii_valid && ascii_ready;
        p_out   = ascii_out;
      end
    end
  end

  initial begin
    string codes[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                         ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                         "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                         "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                         "--...", "---..", "----."};
    string alpha;
    int idx, gap, waited;
    alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

    arst_n = 1'b0; morse_in = 1'b0; ascii_ready = 1'b1; overrun_clr = 1'b0;
    #12;
    chk("rst_out",   {24'h0, ascii_out},   32'h0);
    chk("rst_valid", {31'h0, ascii_valid}, 32'h0);
    chk("rst_err",   {31'h0, decode_err},  32'h0);
    chk("rst_ovr",   {31'h0, overrun},     32'h0);
    @(posedge clk_morse); #1;
    arst_n = 1'b1;
    repeat (2) tick(1'b0);

    // "E" then word gap
    expect_out(8'h45, 1'b0); expect_out(8'h20, 1'b0);
    send(".", 10, 1'b0);

    // "A" then word gap, then long idle produces nothing more
    expect_out(8'h41, 1'b0); expect_out(8'h20, 1'b0);
    send(".-", 10, 1'b0);
    repeat (20) tick(1'b0);

    // six dots: unknown code; seven dots: overflow, no wrap
    expect_out(8'h3F, 1'b1); expect_out(8'h20, 1'b0);
    send("......", 10, 1'b0);
    expect_out(8'h3F, 1'b1); expect_out(8'h20, 1'b0);
    send(".......", 10, 1'b0);

    // Stall: "ET" with ready low keeps E, drops T and the space
    ascii_ready = 1'b0;
    expect_out(8'h45, 1'b0);
    send(".", 3, 1'b0);
    send("-", 3, 1'b0);
    repeat (6) tick(1'b0);
    chk("ovr_set",  {31'h0, overrun},   32'h1);
    chk("ovr_keep", {24'h0, ascii_out}, 32'h45);
    overrun_clr = 1'b1;
    tick(1'b0);
    overrun_clr = 1'b0;
    chk("ovr_clr", {31'h0, overrun}, 32'h0);
    ascii_ready = 1'b1;
    repeat (3) tick(1'b0);
    chk("ovr_drain", {31'h0, ascii_valid}, 32'h0);

    // 20-tick mark saturates the counter and stays a dash
    expect_out(8'h54, 1'b0); expect_out(8'h20, 1'b0);
    repeat (20) tick(1'b1);
    repeat (10) tick(1'b0);

    // Reset in the middle of "-.": partial code discarded
    repeat (3) tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    #2;
    arst_n = 1'b0; morse_in = 1'b0;
    #1;
    chk("midrst_valid", {31'h0, ascii_valid}, 32'h0);
    @(posedge clk_morse); #1;
    arst_n = 1'b1;
    repeat (5) tick(1'b0);
    expect_out(8'h45, 1'b0); expect_out(8'h20, 1'b0);
    send(".", 10, 1'b0);

    // Random text with random ready stalls
    rnd_mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      idx = int'($urandom_range(35, 0));
      if (k == 39)                      gap = 10;
      else if ($urandom_range(1, 0) == 1) gap = int'($urandom_range(6, 3));
      else                              gap = int'($urandom_range(10, 7));
      expect_out(alpha[idx], 1'b0);
      if (gap >= 7) expect_out(8'h20, 1'b0);
      send(codes[idx], gap, 1'b1);
    end
    rnd_mode = 1'b0;
    ascii_ready = 1'b1;

    waited = 0;
    while ((exp_q.size() != 0 || ascii_valid) && waited < 100) begin
      tick(1'b0);
      waited++;
    end
    chk("drain", exp_q.size(), 32'h0);
    chk("ovr_end", {31'h0, overrun}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
